// File: rtl/minibus_pkg.sv
// Shared types and constants for the minibus master controller.
package minibus_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   // Access width encoding carried on the request and on the bus.
   typedef enum logic [1:0] {
      MB_BYTE = 2'b00,
      MB_HALF = 2'b01,
      MB_WORD = 2'b10,
      MB_RSVD = 2'b11
   } minibus_width_t;

   // Controller FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } minibus_state_t;

   // Master-to-slave request bundle.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  wen;
      logic                  ren;
      minibus_width_t        width;
   } minibus_req_t;

   // Slave-to-master result bundle.
   typedef struct packed {
      logic                  ack;
      logic                  err;
      logic [DATA_WIDTH-1:0] rdata;
   } minibus_res_t;

   // True for accesses that must never reach the bus: misaligned halves/words
   // and the reserved width code.
   function automatic logic is_bad_access(input minibus_width_t w, input logic [1:0] lo);
      case (w)
         MB_BYTE: return 1'b0;
         MB_HALF: return lo[0];
         MB_WORD: return |lo;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/minibus_master_if.sv
// Minibus master/slave connection: request driven by the master, result by the slave.
interface minibus_master_if;
   import minibus_pkg::*;

   minibus_req_t req;
   minibus_res_t res;

   modport master (output req, input res);
   modport slave  (input req, output res);
endinterface

// File: rtl/minibus_rdata_align.sv
// Picks the addressed byte/half lane out of a bus word and extends it.
module minibus_rdata_align
   import minibus_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic [1:0]            i_addr_lo,
   input  minibus_width_t        i_width,
   input  logic                  i_signed,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [7:0]  w_lanes [4];
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Split the word into its four byte lanes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lanes[gi] = i_rdata[8*gi +: 8];
      end
   endgenerate

   // Select the lane(s) by address and extend to full width.
   always_comb begin
      w_byte = w_lanes[i_addr_lo];
      w_half = {w_lanes[{i_addr_lo[1], 1'b1}], w_lanes[{i_addr_lo[1], 1'b0}]};
      case (i_width)
         MB_BYTE: o_data = {{(DATA_WIDTH-8){i_signed & w_byte[7]}}, w_byte};
         MB_HALF: o_data = {{(DATA_WIDTH-16){i_signed & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/minibus_master_ctrl.sv
// Core-to-minibus master: accepts one request, runs one bus transfer with a
// cycle timeout, and returns a one-cycle response with aligned read data.
module minibus_master_ctrl
   import minibus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   input  logic                  i_req_wen,
   input  minibus_width_t        i_req_width,
   input  logic                  i_req_signed,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   minibus_master_if.master      m_masterif
);

   // Last value of the wait counter before the transfer is abandoned.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   minibus_state_t        r_state;
   minibus_state_t        w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_wen;
   minibus_width_t        r_width;
   logic                  r_signed;
   logic [7:0]            r_cnt;
   logic [7:0]            w_cnt_next;
   logic                  r_rsp_err;
   logic                  w_rsp_err_next;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_next;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_aligned;
   logic                  w_in_bus;
   minibus_req_t          w_bus_req;

   minibus_rdata_align u_align (
      .i_rdata   (m_masterif.res.rdata),
      .i_addr_lo (r_addr[1:0]),
      .i_width   (r_width),
      .i_signed  (r_signed),
      .o_data    (w_aligned)
   );

   // State register; reset aborts any transfer in flight immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next state, wait counter and response values.
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_accept         = 1'b0;
      w_rsp_err_next   = r_rsp_err;
      w_rsp_rdata_next = r_rsp_rdata;
      case (r_state)
         ST_IDLE: begin
            if (i_req_valid) begin
               w_accept         = 1'b1;
               w_cnt_next       = 8'd0;
               w_rsp_rdata_next = '0;
               if (is_bad_access(i_req_width, i_req_addr[1:0])) begin
                  w_state_next   = ST_RESP;
                  w_rsp_err_next = 1'b1;
               end else begin
                  w_state_next   = ST_BUS;
                  w_rsp_err_next = 1'b0;
               end
            end
         end
         ST_BUS: begin
            // Completion (ack or err) is checked before the timeout so an
            // ack on the last allowed cycle still succeeds.
            if (m_masterif.res.ack || m_masterif.res.err) begin
               w_state_next     = ST_RESP;
               w_rsp_err_next   = m_masterif.res.err;
               w_rsp_rdata_next = (!m_masterif.res.err && !r_wen) ? w_aligned : '0;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_next     = ST_RESP;
               w_rsp_err_next   = 1'b1;
               w_rsp_rdata_next = '0;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         ST_RESP: begin
            w_state_next     = ST_IDLE;
            w_rsp_err_next   = 1'b0;
            w_rsp_rdata_next = '0;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Latched request and response registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wen       <= 1'b0;
         r_width     <= MB_BYTE;
         r_signed    <= 1'b0;
         r_cnt       <= 8'd0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_wen    <= i_req_wen;
            r_width  <= i_req_width;
            r_signed <= i_req_signed;
         end
         r_cnt       <= w_cnt_next;
         r_rsp_err   <= w_rsp_err_next;
         r_rsp_rdata <= w_rsp_rdata_next;
      end
   end

   // Bus strobes only while in BUS; address/data/width held from the latch.
   always_comb begin
      w_in_bus        = (r_state == ST_BUS);
      w_bus_req.addr  = r_addr;
      w_bus_req.wdata = r_wdata;
      w_bus_req.width = r_width;
      w_bus_req.wen   = w_in_bus & r_wen;
      w_bus_req.ren   = w_in_bus & ~r_wen;
   end

   assign m_masterif.req = w_bus_req;
   assign o_req_ready    = (r_state == ST_IDLE);
   assign o_rsp_valid    = (r_state == ST_RESP);
   assign o_rsp_err      = r_rsp_err;
   assign o_rsp_rdata    = r_rsp_rdata;

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// Directed bench for minibus_master_ctrl with a programmable slave responder.
module tb_minibus_master_ctrl;
   import minibus_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [31:0]    req_addr = '0;
   logic [31:0]    req_wdata = '0;
   logic           req_wen = 1'b0;
   minibus_width_t req_width = MB_BYTE;
   logic           req_signed = 1'b0;
   logic           rsp_valid;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;

   minibus_master_if bus_if ();

   minibus_master_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_wen    (req_wen),
      .i_req_width  (req_width),
      .i_req_signed (req_signed),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .m_masterif   (bus_if.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // slave configuration: mode bit0 = ack, bit1 = err, 0 = never respond
   int          sl_delay = 0;
   int          sl_mode  = 0;
   logic [31:0] sl_rdata = '0;
   int          sl_cnt   = 0;

   // monitor counters (only the monitor writes them)
   int ren_cnt = 0;
   int wen_cnt = 0;
   int bus_bad = 0;

   typedef struct {
      logic        wen;
      logic [1:0]  width;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      int          mode;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_ren;
      int          exp_wen;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bus monitor and slave model, evaluated mid-cycle.
   initial begin
      bus_if.res.ack   = 1'b0;
      bus_if.res.err   = 1'b0;
      bus_if.res.rdata = 32'h5A5A5A5A;
      forever begin
         @(negedge clk);
         if (bus_if.req.ren) ren_cnt++;
         if (bus_if.req.wen) wen_cnt++;
         if (bus_if.req.ren || bus_if.req.wen) begin
            if (bus_if.req.addr !== req_addr || bus_if.req.wdata !== req_wdata ||
                2'(bus_if.req.width) !== 2'(req_width) || bus_if.req.wen !== req_wen ||
                bus_if.req.ren !== !req_wen)
               bus_bad++;
            if (sl_cnt == sl_delay && sl_mode != 0) begin
               bus_if.res.ack   = sl_mode[0];
               bus_if.res.err   = sl_mode[1];
               bus_if.res.rdata = sl_rdata;
            end else begin
               bus_if.res.ack   = 1'b0;
               bus_if.res.err   = 1'b0;
               bus_if.res.rdata = 32'h5A5A5A5A;
            end
            sl_cnt++;
         end else begin
            bus_if.res.ack   = 1'b0;
            bus_if.res.err   = 1'b0;
            bus_if.res.rdata = 32'h5A5A5A5A;
            sl_cnt = 0;
         end
      end
   end

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      bit seen;
      int ren0, wen0, bad0;
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_wen    = v.wen;
      req_width  = minibus_width_t'(v.width);
      req_signed = v.sgn;
      sl_delay   = v.delay;
      sl_mode    = v.mode;
      sl_rdata   = v.rdata;
      ren0 = ren_cnt; wen0 = wen_cnt; bad0 = bus_bad;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      seen = 0;
      while (!seen && lat < 40) begin
         if (rsp_valid) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk("rsp_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(v.exp_lat));
      chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("ready_in_resp", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("ren_cycles", 32'(ren_cnt - ren0), 32'(v.exp_ren));
      chk("wen_cycles", 32'(wen_cnt - wen0), 32'(v.exp_wen));
      chk("bus_fields", 32'(bus_bad - bad0), 32'd0);
      $display("txn %0d: wen=%0b width=%0d addr=0x%08h lat=%0d err=%0b rdata=0x%08h",
               idx, v.wen, v.width, v.addr, lat, rsp_err, rsp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            wen width sgn addr   wdata         rdata         dly mode lat err exp_rdata     ren wen
      vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1,  1,  3,  1'b0, 32'hDEADBEEF, 2,  0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h07, 32'h0,        32'h80112233, 0,  1,  2,  1'b0, 32'hFFFFFF80, 1,  0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h07, 32'h0,        32'h80112233, 0,  1,  2,  1'b0, 32'h00000080, 1,  0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h02, 32'h0,        32'h80017FFF, 0,  1,  2,  1'b0, 32'hFFFF8001, 1,  0};
      vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h00, 32'h0,        32'h1234F00D, 0,  1,  2,  1'b0, 32'h0000F00D, 1,  0};
      vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h01, 32'h0,        32'h00007F00, 0,  1,  2,  1'b0, 32'h0000007F, 1,  0};
      vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 32'h12345678, 2,  1,  4,  1'b0, 32'h0,        0,  3};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h0000ABCD, 32'h0,        0,  1,  1,  1'b1, 32'h0,        0,  0};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0,        0,  1,  1,  1'b1, 32'h0,        0,  0};
      vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0,        0,  1,  1,  1'b1, 32'h0,        0,  0};
      vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'hFFFFFFFF, 0,  2,  2,  1'b1, 32'h0,        1,  0};
      vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h11111111, 0,  0,  17, 1'b1, 32'h0,        16, 0};
      vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h05, 32'h0,        32'hAABBCCDD, 0,  3,  2,  1'b1, 32'h0,        1,  0};
      vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h0BADF00D, 15, 1,  17, 1'b0, 32'h0BADF00D, 16, 0};
      vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h0B, 32'h000000A5, 32'hFFFFFFFF, 0,  1,  2,  1'b0, 32'h0,        0,  1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_bus_strobes", 32'({bus_if.req.wen, bus_if.req.ren}), 32'd0);
      chk("rst_bus_addr", bus_if.req.addr, 32'd0);
      chk("rst_bus_wdata", bus_if.req.wdata, 32'd0);
      chk("rst_bus_width", 32'(bus_if.req.width), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // reset on the second BUS cycle of a write
      @(negedge clk);
      req_addr = 32'h14; req_wdata = 32'h55AA55AA; req_wen = 1'b1;
      req_width = MB_WORD; req_signed = 1'b0; sl_mode = 0; sl_delay = 0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_wen_c1", 32'(bus_if.req.wen), 32'd1);
      @(negedge clk);
      chk("rstmid_wen_c2", 32'(bus_if.req.wen), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rstmid_wen_drop", 32'(bus_if.req.wen), 32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
         chk("rstmid_ready_after", 32'(req_ready), 32'd1);
      end
      $display("txn rst-mid-write: aborted, no response");
      run_vec(100, vecs[0]);

      // back-to-back with req_valid held high
      @(negedge clk);
      req_addr = 32'h08; req_wdata = 32'h0; req_wen = 1'b0;
      req_width = MB_WORD; req_signed = 1'b0;
      sl_mode = 1; sl_delay = 0; sl_rdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      @(posedge clk);
      begin
         logic [4:0] exp_ready, exp_valid, exp_ren;
         exp_ready = 5'b00100;   // cycle 1 at bit 0
         exp_valid = 5'b10010;
         exp_ren   = 5'b01001;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 3) req_valid = 1'b0;
            chk("b2b_ready", 32'(req_ready), 32'(exp_ready[c]));
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'(exp_valid[c]));
            chk("b2b_ren", 32'(bus_if.req.ren), 32'(exp_ren[c]));
            if (exp_valid[c]) chk("b2b_rdata", rsp_rdata, 32'hDEADBEEF);
         end
      end
      $display("txn back-to-back: two reads completed");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/minibus_master_ctrl.md
MINIBUS_MASTER_CTRL -- requirements
Module: minibus_master_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the bus cycles waited for ack/err before the transfer aborts; legal range 2..255.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-004 req_valid  in  1  SHALL mark a core request.
REQ-005 req_ready  out  1  SHALL mark that the block accepts a request.
REQ-006 req_addr  in  ADDR_WIDTH  SHALL carry the byte address.
REQ-007 req_wdata  in  DATA_WIDTH  SHALL carry write data, right-aligned.
REQ-008 req_wen  in  1  SHALL select write (1) or read (0).
REQ-009 req_width  in  2  SHALL carry the access width as minibus_width_t (00 byte, 01 half, 10 word).
REQ-010 req_signed  in  1  SHALL select sign-extension (1) or zero-extension (0) of sub-word reads.
REQ-011 rsp_valid  out  1  SHALL be a one-cycle response strobe.
REQ-012 rsp_rdata  out  DATA_WIDTH  SHALL carry aligned, extended read data.
REQ-013 rsp_err  out  1  SHALL flag a failed transfer.
REQ-014 _masterif  minibus_master_if.master  SHALL drive req.{addr,wdata,wen,ren,width} and sample res.{ack,err,rdata}.

Function
REQ-015 The FSM SHALL have states IDLE, BUS, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, req_valid=1 SHALL latch addr/wdata/wen/width/signed and go to BUS.
REQ-018 In IDLE, a misaligned or illegal request (half with addr[0]=1; word with addr[1:0]!=0; width 11) SHALL go directly to RESP with rsp_err=1 and no bus transaction.
REQ-019 In BUS, wen or ren SHALL be driven from the latched request, with addr, wdata and width held stable.
REQ-020 Outside BUS, wen and ren SHALL be 0.
REQ-021 In BUS, a cycle-wait counter SHALL start at 0 on entry and increment each cycle without ack or err.
REQ-022 In BUS, res.ack=1 SHALL go to RESP with rsp_err = res.err.
REQ-023 In BUS, res.err=1 SHALL count as completion with rsp_err=1 even when ack=0.
REQ-024 In BUS, counter = TIMEOUT_CYCLES-1 with no ack/err SHALL go to RESP with rsp_err=1.
REQ-025 An ack in the same cycle as timeout SHALL win; the response SHALL be non-error.
REQ-026 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-027 Minimum latency SHALL be: accept at cycle 0, bus request cycles 1..n, rsp_valid on the cycle after the ack is sampled.
REQ-028 For a read, rsp_rdata SHALL be registered from res.rdata when ack is sampled.
REQ-029 Byte reads SHALL take rdata bits [8*addr[1:0]+7 : 8*addr[1:0]].
REQ-030 Half-word reads SHALL take rdata bits [16*addr[1]+15 : 16*addr[1]].
REQ-031 Sub-word read data SHALL be extended per req_signed.
REQ-032 Writes and errors SHALL return rsp_rdata=0.
REQ-033 The bus SHALL see write data right-aligned as given; lane placement SHALL be left to the slave.

Reset
REQ-034 While rst=1: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus wen/ren/addr/wdata/width=0, counter=0.
REQ-035 rst asserted mid-transfer SHALL abort the transfer immediately with no response ever issued.
REQ-036 After rst deasserts, the first clk edge SHALL be able to accept a request.

Structure
REQ-037 minibus_pkg SHALL hold minibus_width_t and the FSM state enum; ADDR_WIDTH and DATA_WIDTH SHALL come from the same package.
REQ-038 Read-lane extraction and extension SHALL be one combinational sub-module, minibus_rdata_align.

Verification
REQ-039 Word read addr 0x08, slave acks 1 cycle after ren with rdata 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-040 Signed byte read addr 0x07, rdata 0x80112233 -> rsp_rdata 0xFFFFFF80; repeat unsigned -> 0x00000080.
REQ-041 Half write addr 0x03 -> no ren/wen ever asserted, rsp_valid next cycle with rsp_err 1.
REQ-042 Read addr 0x40, sel never given, TIMEOUT_CYCLES=16 -> ren high exactly 16 cycles, then rsp_err 1, rsp_rdata 0.
REQ-043 rst pulsed on the 2nd BUS cycle of a write -> wen drops asynchronously, no rsp_valid, req_ready 1 after release; next read completes normally.
REQ-044 Back-to-back requests with req_valid held high -> second accepted the cycle after RESP; req_ready 0 throughout BUS and RESP.
